multicycle_ctrl: RTL and testbench

- Main control FSM for the multi-cycle RV32I core.
- Sequences the shared datapath (PC, IR, old-PC, A/B, ALUOUT registers, ALU, immediate extender, register file) through fetch, decode, execute, memory and writeback.
- Arbitrates the single unified memory port between instruction fetch and load/store.
- Provides a bus timeout and a retired-instruction counter.

---
 rtl/multicycle_ctrl.sv | 243 ++++++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multi-cycle RV32I core: sequences fetch/decode/execute/memory/writeback
// over the shared datapath, owns the unified memory port, bus timeout and retired-instruction count.
module multicycle_ctrl #(
   parameter int unsigned TIMEOUT = 255,
   parameter int unsigned CNT_W   = 64
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [6:0]       opcode,
   input  logic             branch_taken,
   input  logic             mem_gnt,
   input  logic             mem_rvalid,
   output logic             mem_req,
   output logic             mem_we,
   output logic             addr_sel,
   output logic             ir_we,
   output logic             pc_we,
   output logic             pc_sel,
   output logic             aluout_we,
   output logic [1:0]       alu_a_sel,
   output logic [1:0]       alu_b_sel,
   output logic [1:0]       alu_op_sel,
   output logic             rf_we,
   output logic [1:0]       result_sel,
   output logic             illegal_instr,
   output logic             bus_error,
   output logic [CNT_W-1:0] instret,
   output logic [2:0]       state
);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_FWAIT  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_MWAIT  = 3'd5,
      S_WB     = 3'd6
   } state_e;

   typedef enum logic [3:0] {
      C_NONE, C_OP, C_OPIMM, C_LOAD, C_STORE, C_BRANCH, C_JAL, C_JALR, C_LUI, C_AUIPC
   } cls_e;

   localparam int unsigned   TW     = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [TW-1:0] T_LAST = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;

   state_e           state_q, state_d;
   cls_e             cls_q, cls_d;
   logic [TW-1:0]    wcnt_q, wcnt_d;
   logic [CNT_W-1:0] instret_q, instret_d;
   logic             waiting, evt, timeout, retire;

   function automatic cls_e decode_cls(input logic [6:0] op);
      case (op)
         7'h33:   return C_OP;
         7'h13:   return C_OPIMM;
         7'h03:   return C_LOAD;
         7'h23:   return C_STORE;
         7'h63:   return C_BRANCH;
         7'h6F:   return C_JAL;
         7'h67:   return C_JALR;
         7'h37:   return C_LUI;
         7'h17:   return C_AUIPC;
         default: return C_NONE;
      endcase
   endfunction

   // FETCH and MEM wait on the grant, FWAIT and MWAIT on read data.
   always_comb begin
      waiting = 1'b0;
      evt     = 1'b0;
      case (state_q)
         S_FETCH, S_MEM:  begin waiting = 1'b1; evt = mem_gnt;    end
         S_FWAIT, S_MWAIT: begin waiting = 1'b1; evt = mem_rvalid; end
         default: ;
      endcase
      timeout = (TIMEOUT != 0) && waiting && !evt && (wcnt_q == T_LAST);
   end

   always_comb begin
      // NOTE: every signal gets a default before the case so no path can leave it unassigned (no latches).
      state_d       = state_q;
      cls_d         = cls_q;
      retire        = 1'b0;
      mem_req       = 1'b0;
      mem_we        = 1'b0;
      addr_sel      = 1'b0;
      ir_we         = 1'b0;
      pc_we         = 1'b0;
      pc_sel        = 1'b0;
      aluout_we     = 1'b0;
      alu_a_sel     = 2'd0;
      alu_b_sel     = 2'd0;
      alu_op_sel    = 2'd0;
      rf_we         = 1'b0;
      result_sel    = 2'd0;
      illegal_instr = 1'b0;
      bus_error     = 1'b0;

      case (state_q)
         S_FETCH: begin
            mem_req = 1'b1;
            if (mem_gnt) state_d = S_FWAIT;
         end
         S_FWAIT: begin
            if (mem_rvalid) begin
               ir_we     = 1'b1;
               pc_we     = 1'b1;
               alu_a_sel = 2'd1;
               alu_b_sel = 2'd2;
               state_d   = S_DECODE;
            end
         end
         S_DECODE: begin
            alu_a_sel = 2'd2;
            alu_b_sel = 2'd1;
            aluout_we = 1'b1;
            cls_d     = decode_cls(opcode);
            if (cls_d == C_NONE) begin
               illegal_instr = 1'b1;
               state_d       = S_FETCH;
            end else begin
               state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            case (cls_q)
               C_OP:    begin alu_op_sel = 2'd1; aluout_we = 1'b1; state_d = S_WB; end
               C_OPIMM: begin alu_b_sel = 2'd1; alu_op_sel = 2'd1; aluout_we = 1'b1; state_d = S_WB; end
               C_LUI:   begin alu_a_sel = 2'd3; alu_b_sel = 2'd1; aluout_we = 1'b1; state_d = S_WB; end
               C_AUIPC: begin alu_a_sel = 2'd2; alu_b_sel = 2'd1; aluout_we = 1'b1; state_d = S_WB; end
               C_LOAD, C_STORE: begin
                  alu_b_sel = 2'd1;
                  aluout_we = 1'b1;
                  state_d   = S_MEM;
               end
               C_BRANCH: begin
                  alu_op_sel = 2'd2;
                  pc_we      = branch_taken;
                  pc_sel     = branch_taken;
                  retire     = 1'b1;
                  state_d    = S_FETCH;
               end
               C_JAL: begin
                  pc_we      = 1'b1;
                  pc_sel     = 1'b1;
                  rf_we      = 1'b1;
                  result_sel = 2'd2;
                  retire     = 1'b1;
                  state_d    = S_FETCH;
               end
               // rs1 already sits in A, so overwriting rd==rs1 here cannot corrupt the target.
               C_JALR: begin
                  alu_b_sel  = 2'd1;
                  pc_we      = 1'b1;
                  rf_we      = 1'b1;
                  result_sel = 2'd2;
                  retire     = 1'b1;
                  state_d    = S_FETCH;
               end
               default: state_d = S_FETCH;
            endcase
         end
         S_MEM: begin
            mem_req  = 1'b1;
            addr_sel = 1'b1;
            mem_we   = (cls_q == C_STORE);
            if (mem_gnt) begin
               if (cls_q == C_STORE) begin
                  retire  = 1'b1;
                  state_d = S_FETCH;
               end else begin
                  state_d = S_MWAIT;
               end
            end
         end
         S_MWAIT: begin
            if (mem_rvalid) begin
               rf_we      = 1'b1;
               result_sel = 2'd1;
               retire     = 1'b1;
               state_d    = S_FETCH;
            end
         end
         S_WB: begin
            rf_we   = 1'b1;
            retire  = 1'b1;
            state_d = S_FETCH;
         end
         default: state_d = S_FETCH;
      endcase

      if (timeout) begin
         bus_error = 1'b1;
         state_d   = S_FETCH;
      end

      // The bus sees nothing from the controller while reset is held.
      if (!rst_n) begin
         mem_req       = 1'b0;
         mem_we        = 1'b0;
         addr_sel      = 1'b0;
         ir_we         = 1'b0;
         pc_we         = 1'b0;
         pc_sel        = 1'b0;
         aluout_we     = 1'b0;
         alu_a_sel     = 2'd0;
         alu_b_sel     = 2'd0;
         alu_op_sel    = 2'd0;
         rf_we         = 1'b0;
         result_sel    = 2'd0;
         illegal_instr = 1'b0;
         bus_error     = 1'b0;
         retire        = 1'b0;
      end

      if (timeout || (state_d != state_q)) wcnt_d = '0;
      else if (waiting && (TIMEOUT != 0))  wcnt_d = wcnt_q + TW'(1);
      else                                 wcnt_d = wcnt_q;

      instret_d = instret_q + CNT_W'(retire);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_FETCH;
         cls_q     <= C_NONE;
         wcnt_q    <= '0;
         instret_q <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so all registers update together.
         state_q   <= state_d;
         cls_q     <= cls_d;
         wcnt_q    <= wcnt_d;
         instret_q <= instret_d;
      end
   end

   assign state   = state_q;
   assign instret = instret_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: a directed cycle table, hand-built corner sequences and
// randomized instructions whose expected per-cycle traces come from a transaction-level model.
module tb_multicycle_ctrl;

   localparam int T  = 8;
   localparam int CW = 4;

   // Expected-vector layout: {state[2:0], req, we, asel, irwe, pcwe, pcsel, aowe, a[1:0], b[1:0], op[1:0], rfwe, res[1:0], ill, berr}
   localparam logic [20:0] ST_FE = 21'd0 << 18;
   localparam logic [20:0] ST_FW = 21'd1 << 18;
   localparam logic [20:0] ST_DE = 21'd2 << 18;
   localparam logic [20:0] ST_EX = 21'd3 << 18;
   localparam logic [20:0] ST_ME = 21'd4 << 18;
   localparam logic [20:0] ST_MW = 21'd5 << 18;
   localparam logic [20:0] ST_WB = 21'd6 << 18;
   localparam logic [20:0] REQ   = 21'd1 << 17;
   localparam logic [20:0] WE    = 21'd1 << 16;
   localparam logic [20:0] ASEL  = 21'd1 << 15;
   localparam logic [20:0] IRWE  = 21'd1 << 14;
   localparam logic [20:0] PCWE  = 21'd1 << 13;
   localparam logic [20:0] PCSEL = 21'd1 << 12;
   localparam logic [20:0] AOWE  = 21'd1 << 11;
   localparam logic [20:0] A_PC  = 21'd1 << 9;
   localparam logic [20:0] A_OPC = 21'd2 << 9;
   localparam logic [20:0] A_Z   = 21'd3 << 9;
   localparam logic [20:0] B_IMM = 21'd1 << 7;
   localparam logic [20:0] B_4   = 21'd2 << 7;
   localparam logic [20:0] OP_FN = 21'd1 << 5;
   localparam logic [20:0] OP_BR = 21'd2 << 5;
   localparam logic [20:0] RFWE  = 21'd1 << 4;
   localparam logic [20:0] R_MEM = 21'd1 << 2;
   localparam logic [20:0] R_PC  = 21'd2 << 2;
   localparam logic [20:0] ILL   = 21'd1 << 1;
   localparam logic [20:0] BERR  = 21'd1;
   localparam logic [20:0] FW_OK = ST_FW | IRWE | PCWE | A_PC | B_4;
   localparam logic [20:0] DEC   = ST_DE | A_OPC | B_IMM | AOWE;

   typedef struct {
      logic        gnt;
      logic        rv;
      logic        bt;
      logic [6:0]  opc;
      logic [20:0] exp;
      logic [CW-1:0] ir;
   } cyc_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [6:0] opcode = 7'h00;
   logic branch_taken = 1'b0, mem_gnt = 1'b0, mem_rvalid = 1'b0;
   logic mem_req, mem_we, addr_sel, ir_we, pc_we, pc_sel, aluout_we, rf_we, illegal_instr, bus_error;
   logic [1:0] alu_a_sel, alu_b_sel, alu_op_sel, result_sel;
   logic [CW-1:0] instret;
   logic [2:0] state;

   int checks = 0;
   int errors = 0;
   int item   = 0;
   cyc_t q[$];
   logic [CW-1:0] m_ir = '0;
   logic [6:0] legal_ops [9] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17};

   multicycle_ctrl #(.TIMEOUT(T), .CNT_W(CW)) dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .branch_taken(branch_taken),
      .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_req(mem_req), .mem_we(mem_we),
      .addr_sel(addr_sel), .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel), .aluout_we(aluout_we),
      .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel), .alu_op_sel(alu_op_sel), .rf_we(rf_we),
      .result_sel(result_sel), .illegal_instr(illegal_instr), .bus_error(bus_error),
      .instret(instret), .state(state)
   );

   always #5 clk = ~clk;

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit expired");
      $fatal(1);
   end

   function automatic logic [20:0] act_vec();
      return {state, mem_req, mem_we, addr_sel, ir_we, pc_we, pc_sel, aluout_we,
              alu_a_sel, alu_b_sel, alu_op_sel, rf_we, result_sel, illegal_instr, bus_error};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic rb();
      return $urandom_range(0, 1) != 0;
   endfunction

   function automatic logic is_legal(input logic [6:0] op);
      foreach (legal_ops[i]) if (legal_ops[i] == op) return 1'b1;
      return 1'b0;
   endfunction

   function automatic void emit(input logic g, input logic rv, input logic bt, input logic [6:0] opc,
                                input logic [20:0] e, input logic ret);
      cyc_t c;
      c.gnt = g; c.rv = rv; c.bt = bt; c.opc = opc; c.exp = e; c.ir = m_ir;
      q.push_back(c);
      if (ret) m_ir = m_ir + 1'b1;
   endfunction

   // Abandoned wait: T cycles without the awaited event, bus_error on the last one.
   function automatic void emit_abort(input logic [6:0] opc, input logic [20:0] e);
      for (int i = 0; i < T; i++) emit(1'b0, 1'b0, rb(), opc, e | ((i == T - 1) ? BERR : 21'd0), 1'b0);
   endfunction

   // Whole-instruction trace from the per-state rules; delays count cycles without gnt/rvalid.
   function automatic void gen(input logic [6:0] opc, input int gf, input int rf, input int gm,
                               input int rm, input logic bt, input logic xr);
      int g = gf;
      logic st;
      logic [20:0] me;
      while (g >= T) begin
         emit_abort(opc, ST_FE | REQ);
         g -= T;
      end
      repeat (g) emit(1'b0, 1'b0, rb(), opc, ST_FE | REQ, 1'b0);
      emit(1'b1, xr, rb(), opc, ST_FE | REQ, 1'b0);
      if (rf >= T) begin emit_abort(opc, ST_FW); return; end
      repeat (rf) emit(1'b0, 1'b0, rb(), opc, ST_FW, 1'b0);
      emit(1'b0, 1'b1, rb(), opc, FW_OK, 1'b0);
      if (!is_legal(opc)) begin emit(1'b0, 1'b0, rb(), opc, DEC | ILL, 1'b0); return; end
      emit(1'b0, 1'b0, rb(), opc, DEC, 1'b0);
      case (opc)
         7'h33: begin emit(0, 0, rb(), opc, ST_EX | OP_FN | AOWE, 0);          emit(0, 0, rb(), opc, ST_WB | RFWE, 1); end
         7'h13: begin emit(0, 0, rb(), opc, ST_EX | B_IMM | OP_FN | AOWE, 0);  emit(0, 0, rb(), opc, ST_WB | RFWE, 1); end
         7'h37: begin emit(0, 0, rb(), opc, ST_EX | A_Z | B_IMM | AOWE, 0);    emit(0, 0, rb(), opc, ST_WB | RFWE, 1); end
         7'h17: begin emit(0, 0, rb(), opc, ST_EX | A_OPC | B_IMM | AOWE, 0);  emit(0, 0, rb(), opc, ST_WB | RFWE, 1); end
         7'h63: emit(0, 0, bt, opc, ST_EX | OP_BR | (bt ? (PCWE | PCSEL) : 21'd0), 1);
         7'h6F: emit(0, 0, rb(), opc, ST_EX | PCWE | PCSEL | RFWE | R_PC, 1);
         7'h67: emit(0, 0, rb(), opc, ST_EX | B_IMM | PCWE | RFWE | R_PC, 1);
         default: begin
            st = (opc == 7'h23);
            me = ST_ME | REQ | ASEL | (st ? WE : 21'd0);
            emit(0, 0, rb(), opc, ST_EX | B_IMM | AOWE, 0);
            if (gm >= T) begin emit_abort(opc, me); return; end
            repeat (gm) emit(1'b0, 1'b0, rb(), opc, me, 1'b0);
            emit(1'b1, xr, rb(), opc, me, st);
            if (st) return;
            if (rm >= T) begin emit_abort(opc, ST_MW); return; end
            repeat (rm) emit(1'b0, 1'b0, rb(), opc, ST_MW, 1'b0);
            emit(1'b0, 1'b1, rb(), opc, ST_MW | RFWE | R_MEM, 1'b1);
         end
      endcase
   endfunction

   // Entered just after a rising edge; drives one cycle, samples on the falling edge.
   task automatic run_n(input int n);
      cyc_t c;
      for (int k = 0; k < n && q.size() > 0; k++) begin
         c = q.pop_front();
         opcode = c.opc; mem_gnt = c.gnt; mem_rvalid = c.rv; branch_taken = c.bt;
         @(negedge clk);
         item++;
         check($sformatf("item%0d outputs", item), 32'(act_vec()), 32'(c.exp));
         check($sformatf("item%0d instret", item), 32'(instret), 32'(c.ir));
         @(posedge clk);
         #1;
      end
   endtask

   function automatic int rdly();
      int r = $urandom_range(0, 19);
      if (r < 14) return r % 3;
      if (r < 18) return $urandom_range(3, 7);
      return $urandom_range(8, 12);
   endfunction

   cyc_t tbl [24];

   initial begin
      tbl = '{
         '{1, 0, 0, 7'h13, ST_FE | REQ, 0}, '{0, 1, 0, 7'h13, FW_OK, 0}, '{0, 0, 0, 7'h13, DEC, 0},
         '{0, 0, 0, 7'h13, ST_EX | B_IMM | OP_FN | AOWE, 0}, '{0, 0, 0, 7'h13, ST_WB | RFWE, 0},
         '{1, 0, 0, 7'h63, ST_FE | REQ, 1}, '{0, 1, 0, 7'h63, FW_OK, 1}, '{0, 0, 0, 7'h63, DEC, 1},
         '{0, 0, 1, 7'h63, ST_EX | OP_BR | PCWE | PCSEL, 1},
         '{1, 0, 1, 7'h63, ST_FE | REQ, 2}, '{0, 1, 1, 7'h63, FW_OK, 2}, '{0, 0, 1, 7'h63, DEC, 2},
         '{0, 0, 0, 7'h63, ST_EX | OP_BR, 2},
         '{1, 0, 0, 7'h6F, ST_FE | REQ, 3}, '{0, 1, 0, 7'h6F, FW_OK, 3}, '{0, 0, 0, 7'h6F, DEC, 3},
         '{0, 0, 0, 7'h6F, ST_EX | PCWE | PCSEL | RFWE | R_PC, 3},
         '{1, 0, 0, 7'h67, ST_FE | REQ, 4}, '{0, 1, 0, 7'h67, FW_OK, 4}, '{0, 0, 0, 7'h67, DEC, 4},
         '{0, 0, 0, 7'h67, ST_EX | B_IMM | PCWE | RFWE | R_PC, 4},
         '{1, 0, 0, 7'h7F, ST_FE | REQ, 5}, '{0, 1, 0, 7'h7F, FW_OK, 5}, '{0, 0, 0, 7'h7F, DEC | ILL, 5}
      };

      // Reset state, with handshake inputs active to show they are ignored.
      mem_gnt = 1'b1; mem_rvalid = 1'b1; opcode = 7'h13;
      repeat (2) @(posedge clk);
      #1;
      check("reset outputs", 32'(act_vec()), 32'd0);
      check("reset instret", 32'(instret), 32'd0);
      rst_n = 1'b1;

      for (int i = 0; i < 24; i++) q.push_back(tbl[i]);
      m_ir = 4'd5;
      run_n(q.size());

      // Stuck grant: fetch abandons after T cycles and retries; then a LW with slow data and a dropped store.
      gen(7'h33, T, 0, 0, 0, 1'b0, 1'b0);
      gen(7'h03, 0, 0, 2, 2, 1'b0, 1'b0);
      gen(7'h23, 0, 0, T + 1, 0, 1'b0, 1'b0);
      gen(7'h03, 0, 0, 0, T, 1'b0, 1'b1);
      run_n(q.size());

      // Reset pulse while in MWAIT, then a stale read response after release.
      gen(7'h03, 0, 0, 0, 6, 1'b0, 1'b0);
      run_n(7);
      q.delete();
      mem_gnt = 1'b0; mem_rvalid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check("async reset outputs", 32'(act_vec()), 32'd0);
      check("async reset instret", 32'(instret), 32'd0);
      @(posedge clk);
      #1;
      check("held reset outputs", 32'(act_vec()), 32'd0);
      rst_n = 1'b1;
      m_ir = '0;
      emit(1'b0, 1'b1, 1'b0, 7'h03, ST_FE | REQ, 1'b0);
      gen(7'h13, 0, 0, 0, 0, 1'b0, 1'b0);
      run_n(q.size());

      for (int n = 0; n < 300; n++) begin
         logic [6:0] op;
         if ($urandom_range(0, 9) == 0) begin
            do op = 7'($urandom_range(0, 127)); while (is_legal(op));
         end else begin
            op = legal_ops[$urandom_range(0, 8)];
         end
         gen(op, rdly(), rdly(), rdly(), rdly(), rb(), rb());
         run_n(q.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
